// File: rtl/keypad_pkg.sv
// keypad_pkg: shared types and constants for the 4x4 matrix keypad scanner.
//   NUM_ROWS / NUM_COLS : keypad geometry
//   CODE_W              : width of a key code (row*4 + col)
//   frame_result_e      : classification of one full scan frame
//   db_state_e          : debounce FSM states
//   count_low()         : number of active-low (closed) bits in a row sample
package keypad_pkg;

  localparam int NUM_ROWS = 4;
  localparam int NUM_COLS = 4;
  localparam int CODE_W   = 4;

  typedef enum logic [1:0] {
    FR_NONE,
    FR_SINGLE,
    FR_MULTI
  } frame_result_e;

  typedef enum logic [1:0] {
    DB_IDLE,
    DB_CAND,
    DB_PRESSED,
    DB_REL
  } db_state_e;

  function automatic logic [2:0] count_low(input logic [NUM_ROWS-1:0] rows);
    logic [2:0] n;
    n = '0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      n = n + {2'b00, ~rows[r]};
    end
    return n;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// keypad_debounce: frame-level debounce FSM for the keypad scanner.
// Evaluated only on frame-closing edges (frame_done=1).
//   clk, rst    : clock, synchronous active-high reset
//   frame_done  : 1 on the edge that closes a scan frame
//   frame_res   : NONE / SINGLE / MULTI result of the closing frame
//   frame_code  : key code when frame_res is SINGLE
//   confirm     : combinational pulse on the closing edge that confirms a press
//   code        : key code being confirmed (valid with confirm)
//   held        : debounced key currently down
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_done,
  input  frame_result_e     frame_res,
  input  logic [CODE_W-1:0] frame_code,
  output logic              confirm,
  output logic [CODE_W-1:0] code,
  output logic              held
);

  localparam int CNT_W = $clog2(DEBOUNCE_FRAMES + 1);
  localparam logic [CNT_W-1:0] DB_TARGET = CNT_W'(DEBOUNCE_FRAMES);

  db_state_e         state, state_next;
  logic [CODE_W-1:0] cand, cand_next;
  logic [CNT_W-1:0]  cnt, cnt_next, cnt_inc;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= DB_IDLE;
      cand  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cand  <= cand_next;
      cnt   <= cnt_next;
    end
  end

  // Saturating so the counter can never wrap back below the target.
  assign cnt_inc = (cnt == DB_TARGET) ? cnt : cnt + CNT_W'(1);

  always_comb begin
    state_next = state;
    cand_next  = cand;
    cnt_next   = cnt;
    confirm    = 1'b0;
    if (frame_done) begin
      case (state)
        DB_IDLE: begin
          if (frame_res == FR_SINGLE) begin
            cand_next = frame_code;
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = DB_PRESSED;
              confirm    = 1'b1;
              cnt_next   = '0;
            end else begin
              state_next = DB_CAND;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        DB_CAND: begin
          if (frame_res == FR_SINGLE && frame_code == cand) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_next = DB_PRESSED;
              confirm    = 1'b1;
              cnt_next   = '0;
            end
          end else if (frame_res == FR_SINGLE) begin
            cand_next = frame_code;
            cnt_next  = CNT_W'(1);
          end else begin
            state_next = DB_IDLE;
            cnt_next   = '0;
          end
        end
        DB_PRESSED: begin
          // Ghosting or a second key never counts as a release.
          if (frame_res == FR_NONE) begin
            if (DEBOUNCE_FRAMES == 1) begin
              state_next = DB_IDLE;
              cnt_next   = '0;
            end else begin
              state_next = DB_REL;
              cnt_next   = CNT_W'(1);
            end
          end
        end
        DB_REL: begin
          if (frame_res == FR_NONE) begin
            cnt_next = cnt_inc;
            if (cnt_inc == DB_TARGET) begin
              state_next = DB_IDLE;
              cnt_next   = '0;
            end
          end else begin
            state_next = DB_PRESSED;
            cnt_next   = '0;
          end
        end
        default: begin
          state_next = DB_IDLE;
          cnt_next   = '0;
        end
      endcase
    end
  end

  // Code is only meaningful alongside confirm; it carries the candidate being accepted.
  assign code = cand_next;
  assign held = (state == DB_PRESSED) || (state == DB_REL);

endmodule

// File: rtl/keypad_scan_ctrl.sv
// keypad_scan_ctrl: 4x4 matrix keypad scan controller.
// Drives one column low per slot, samples rows at the end of each slot,
// classifies each 4-slot frame, debounces at frame level and presents one
// key code per press over a valid/ack handshake.
//   clk, rst    : clock, synchronous active-high reset
//   key_in      : row inputs, active-low, bit r = row r
//   key_out     : column drive, active-low, exactly one bit low
//   key_code    : confirmed key, row*4 + col
//   key_valid   : key_code holds an unacknowledged press
//   key_ack     : consumer accepts key_code (only while key_valid=1)
//   key_held    : debounced key currently down
//   key_overrun : one-cycle pulse when a confirmed press was dropped
module keypad_scan_ctrl
  import keypad_pkg::*;
#(
  parameter int SLOT_CYCLES     = 100000,
  parameter int DEBOUNCE_FRAMES = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NUM_ROWS-1:0] key_in,
  output logic [NUM_COLS-1:0] key_out,
  output logic [CODE_W-1:0] key_code,
  output logic              key_valid,
  input  logic              key_ack,
  output logic              key_held,
  output logic              key_overrun
);

  localparam int SLOT_W = $clog2(SLOT_CYCLES);
  localparam logic [SLOT_W-1:0] SLOT_LAST = SLOT_W'(SLOT_CYCLES - 1);

  logic [SLOT_W-1:0] slot_cnt;
  logic [1:0]        col, col_next;
  logic              slot_end, frame_done;

  logic [2:0]        samp_hits, acc_hits, tot_hits;
  logic [3:0]        hit_sum;
  logic [1:0]        samp_row;
  logic [CODE_W-1:0] acc_code, frame_code;
  frame_result_e     frame_res;

  logic              db_confirm;
  logic [CODE_W-1:0] db_code;

  assign slot_end   = (slot_cnt == SLOT_LAST);
  assign frame_done = slot_end && (col == 2'(NUM_COLS - 1));
  assign col_next   = col + 2'd1;

  // NOTE: every signal written in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    samp_row = '0;
    // Ascending scan: the highest closed row index is the one kept.
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (!key_in[r]) samp_row = 2'(r);
    end
  end

  assign samp_hits = count_low(key_in);
  assign hit_sum   = {1'b0, acc_hits} + {1'b0, samp_hits};
  // Saturate: a wrap to 0 would turn a crowded frame into NONE.
  assign tot_hits  = hit_sum[3] ? 3'd7 : hit_sum[2:0];
  assign frame_code = (samp_hits != 3'd0) ? {samp_row, col} : acc_code;

  always_comb begin
    frame_res = FR_MULTI;
    if (tot_hits == 3'd0)      frame_res = FR_NONE;
    else if (tot_hits == 3'd1) frame_res = FR_SINGLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt <= '0;
      col      <= '0;
      key_out  <= 4'b1110;
      acc_hits <= '0;
      acc_code <= '0;
    end else if (slot_end) begin
      slot_cnt <= '0;
      col      <= col_next;
      key_out  <= ~(4'b0001 << col_next);
      if (frame_done) begin
        acc_hits <= '0;
        acc_code <= '0;
      end else begin
        acc_hits <= tot_hits;
        acc_code <= frame_code;
      end
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  keypad_debounce #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debounce (
    .clk        (clk),
    .rst        (rst),
    .frame_done (frame_done),
    .frame_res  (frame_res),
    .frame_code (frame_code),
    .confirm    (db_confirm),
    .code       (db_code),
    .held       (key_held)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      key_code    <= '0;
      key_valid   <= 1'b0;
      key_overrun <= 1'b0;
    end else begin
      key_overrun <= 1'b0;
      if (db_confirm) begin
        if (!key_valid) begin
          key_code  <= db_code;
          key_valid <= 1'b1;
        end else if (key_ack) begin
          // Ack and a fresh press on the same edge: hand over the new code.
          key_code <= db_code;
        end else begin
          key_overrun <= 1'b1;
        end
      end else if (key_valid && key_ack) begin
        key_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_keypad_scan_ctrl.sv
// tb_keypad_scan_ctrl: self-checking bench for keypad_scan_ctrl.
// Models the keypad as a set of closed keys and predicts each frame's
// outcome from streak counts of identical frames.
module tb_keypad_scan_ctrl;

  localparam int SLOT = 8;
  localparam int NDB  = 3;
  localparam int FRAME = 4 * SLOT;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] key_in;
  logic [3:0] key_out;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ack = 1'b0;
  logic       key_held;
  logic       key_overrun;

  logic [15:0] mask = '0;   // bit r*4+c set = key (r,c) closed

  int checks = 0;
  int errors = 0;

  // Reference state
  int m_held, m_streak_code, m_streak_len, m_rel_len, m_valid, m_code;

  always #5 clk = ~clk;

  keypad_scan_ctrl #(
    .SLOT_CYCLES     (SLOT),
    .DEBOUNCE_FRAMES (NDB)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .key_in      (key_in),
    .key_out     (key_out),
    .key_code    (key_code),
    .key_valid   (key_valid),
    .key_ack     (key_ack),
    .key_held    (key_held),
    .key_overrun (key_overrun)
  );

  // Physical keypad: a row reads low when a closed key sits in a driven column.
  always_comb begin
    key_in = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!key_out[c] && mask[r*4+c]) key_in[r] = 1'b0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_held = 0; m_streak_code = 0; m_streak_len = 0; m_rel_len = 0;
    m_valid = 0; m_code = 0;
  endtask

  // One frame closes with the current mask; returns expected overrun pulses.
  task automatic model_frame(input bit ack_close, output int ovr_exp);
    int n, k, confirm;
    n = $countones(mask);
    k = 0;
    for (int i = 0; i < 16; i++) if (mask[i]) k = i;
    confirm = 0;
    ovr_exp = 0;
    if (m_held == 0) begin
      if (n == 1) begin
        if (m_streak_len > 0 && k == m_streak_code) m_streak_len++;
        else begin m_streak_code = k; m_streak_len = 1; end
        if (m_streak_len >= NDB) begin
          m_held = 1; confirm = 1; m_streak_len = 0; m_rel_len = 0;
        end
      end else begin
        m_streak_len = 0;
      end
    end else begin
      if (n == 0) begin
        m_rel_len++;
        if (m_rel_len >= NDB) begin m_held = 0; m_rel_len = 0; end
      end else begin
        m_rel_len = 0;
      end
    end
    if (confirm != 0) begin
      if (m_valid == 0) begin m_code = m_streak_code; m_valid = 1; end
      else if (ack_close) m_code = m_streak_code;
      else ovr_exp = 1;
    end else if (m_valid != 0 && ack_close) begin
      m_valid = 0;
    end
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    repeat (n) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();
    check("rst_key_out",   32'(key_out), 32'(4'b1110));
    check("rst_valid",     32'(key_valid), 32'd0);
    check("rst_code",      32'(key_code), 32'd0);
    check("rst_held",      32'(key_held), 32'd0);
    check("rst_overrun",   32'(key_overrun), 32'd0);
  endtask

  // Runs ncyc cycles of a frame with mask m; ack_at = cycle whose edge sees key_ack
  // (31 = frame-closing edge, -1 = none). Checks at close only when ncyc == FRAME.
  task automatic run_frame(input logic [15:0] m, input int ack_at, input int ncyc);
    int ovr_seen, ovr_exp;
    logic [3:0] exp_out;
    mask = m;
    ovr_seen = 0;
    for (int i = 0; i < ncyc; i++) begin
      key_ack = (i == ack_at);
      @(posedge clk);
      #1;
      key_ack = 1'b0;
      if (key_overrun) ovr_seen++;
      if ((i + 1) % SLOT == 0) begin
        exp_out = ~(4'b0001 << (((i + 1) / SLOT) % 4));
        check("key_out", 32'(key_out), 32'(exp_out));
      end
      if (i == ack_at && i != FRAME - 1) begin
        m_valid = 0;
        check("valid_after_ack", 32'(key_valid), 32'(m_valid));
        check("code_after_ack", 32'(key_code), 32'(m_code));
      end
      if (i == FRAME - 1) begin
        model_frame(ack_at == FRAME - 1, ovr_exp);
        check("valid",   32'(key_valid), 32'(m_valid));
        check("code",    32'(key_code), 32'(m_code));
        check("held",    32'(key_held), 32'(m_held));
        check("overrun_cycles", 32'(ovr_seen), 32'(ovr_exp));
      end
    end
  endtask

  task automatic frames(input logic [15:0] m, input int n);
    repeat (n) run_frame(m, -1, FRAME);
  endtask

  function automatic logic [15:0] key_bit(input int r, input int c);
    logic [15:0] v;
    v = '0;
    v[r*4+c] = 1'b1;
    return v;
  endfunction

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, hold, ack_at, a, b;
    logic [15:0] m;
    model_reset();
    do_reset(3);

    // Idle: no keys for 10 frames.
    frames('0, 10);

    // Single press (2,1) -> code 9, ack, then held 10 more frames.
    frames(key_bit(2, 1), 3);
    check("press_code_9", 32'(key_code), 32'd9);
    run_frame(key_bit(2, 1), 5, FRAME);
    frames(key_bit(2, 1), 10);

    // Release, then repress (0,0).
    frames('0, 3);
    check("released", 32'(key_held), 32'd0);
    frames(key_bit(0, 0), 3);
    check("repress_code_0", 32'(key_code), 32'd0);
    check("repress_valid", 32'(key_valid), 32'd1);
    run_frame('0, 10, FRAME);
    frames('0, 2);

    // Bounce on (1,3): 2 closed, 1 open, 3 closed -> one event, code 7.
    frames(key_bit(1, 3), 2);
    frames('0, 1);
    frames(key_bit(1, 3), 3);
    check("bounce_code_7", 32'(key_code), 32'd7);
    run_frame('0, 2, FRAME);
    frames('0, 2);

    // Overrun: 5 unacked, release, 10 confirmed -> dropped.
    frames(key_bit(1, 1), 3);
    frames('0, 3);
    frames(key_bit(2, 2), 3);
    check("overrun_keeps_5", 32'(key_code), 32'd5);
    run_frame('0, 4, FRAME);
    frames('0, 2);

    // Collision: ack on the confirm edge of 10.
    frames(key_bit(1, 1), 3);
    frames('0, 3);
    frames(key_bit(2, 2), 2);
    run_frame(key_bit(2, 2), FRAME - 1, FRAME);
    check("collision_code_10", 32'(key_code), 32'd10);
    check("collision_valid", 32'(key_valid), 32'd1);
    run_frame('0, 0, FRAME);
    frames('0, 2);

    // Two keys together from idle -> no event.
    frames(key_bit(0, 0) | key_bit(3, 3), 4);
    frames('0, 3);

    // Reset discards a partially debounced press.
    frames(key_bit(2, 2), 2);
    do_reset(1);
    frames(key_bit(2, 2), 2);
    check("no_event_after_rst", 32'(key_valid), 32'd0);
    frames(key_bit(2, 2), 1);
    check("event_after_rst", 32'(key_code), 32'd10);

    // Reset in the middle of a frame.
    run_frame(key_bit(0, 3), -1, 13);
    do_reset(2);
    frames(key_bit(0, 3), 3);
    run_frame('0, 7, FRAME);
    frames('0, 2);

    // Randomized key activity.
    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        m = '0;
      end else if (kind < 9) begin
        m = key_bit($urandom_range(0, 3), $urandom_range(0, 3));
      end else begin
        a = $urandom_range(0, 15);
        b = (a + 1 + $urandom_range(0, 14)) % 16;
        m = '0;
        m[a] = 1'b1;
        m[b] = 1'b1;
      end
      hold = $urandom_range(1, 4);
      for (int f = 0; f < hold; f++) begin
        if ($urandom_range(0, 3) == 0)
          ack_at = ($urandom_range(0, 1) == 1) ? FRAME - 1 : $urandom_range(0, FRAME - 2);
        else
          ack_at = -1;
        run_frame(m, ack_at, FRAME);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/keypad_scan_ctrl.md
Name: keypad_scan_ctrl

Overview:
Scan controller for the 4x4 matrix keypad. It drives one column low at a time on key_out, samples the rows on key_in after a settle window and debounces at frame level. It delivers one registered key code per press over a valid/ack handshake. It replaces ad-hoc column poking in the top level and feeds the calculator datapath and the display value logic.

Parameters:
SLOT_CYCLES, 100000, clk cycles per column slot (settle and sample); must be >= 2
DEBOUNCE_FRAMES, 3, consecutive identical frames required to confirm a press or a release; must be >= 1

Ports:
clk  in  1  system clock
rst  in  1  reset; synchronous, active-high
key_in  in  4  row inputs, active-low (0 = key closed in the driven column); bit r = row r
key_out  out  4  column drive, active-low, exactly one bit low; bit c = column c
key_code  out  4  confirmed key, row*4 + col
key_valid  out  1  key_code holds an unacknowledged press
key_ack  in  1  consumer accepts key_code; sampled only while key_valid=1
key_held  out  1  debounced key currently down
key_overrun  out  1  one-cycle pulse: a confirmed press was dropped because key_valid was still 1

Behaviour:
- Reset values: key_out=4'b1110, key_code=0, key_valid=0, key_held=0, key_overrun=0. Slot counter=0, column=0, debounce state IDLE, frame counter=0, frame accumulators cleared.
- rst asserted mid-operation: every register returns to its reset value on that edge. A partially debounced press is discarded.
- Slot timing:
  - Slot counter runs 0..SLOT_CYCLES-1.
  - key_in is sampled when the counter equals SLOT_CYCLES-1.
  - On that same edge the column advances 0->1->2->3->0, and key_out = ~(1<<col).
  - Frame = 4 slots = 4*SLOT_CYCLES cycles.
- Frame accumulation:
  - Each sample adds the count of low row bits to a 3-bit hit counter and records the last hit (row, col).
  - Rows are scanned in index order within a sample; with several hits the last recorded hit is the highest row index.
  - The column-3 sample closes the frame, including its own hits.
  - Frame result: NONE (0 hits), SINGLE(code) (exactly 1 hit), MULTI (>=2 hits).
  - Accumulators clear on the closing edge.
- Debounce FSM (evaluated on the frame-closing edge only):
  - IDLE: SINGLE(k) -> CAND with cand=k, cnt=1. Stays IDLE otherwise. If DEBOUNCE_FRAMES=1, go directly to PRESSED and confirm.
  - CAND:
    - SINGLE(cand): cnt+1; on reaching DEBOUNCE_FRAMES go to PRESSED and confirm.
    - SINGLE(other): restart with cand=other, cnt=1.
    - NONE or MULTI: go to IDLE.
  - PRESSED: key_held=1. NONE -> REL with cnt=1. SINGLE or MULTI stays PRESSED; ghosting or a second key never releases.
  - REL:
    - NONE: cnt+1; on reaching DEBOUNCE_FRAMES go to IDLE with key_held=0.
    - SINGLE or MULTI: back to PRESSED.
- Confirm:
  - Happens on the frame-closing edge; key_valid and key_code are visible the next cycle.
  - If key_valid=0: key_code=cand, key_valid=1.
  - If key_valid=1 and key_ack=0: the new code is dropped, key_code keeps the old value, key_overrun=1 for one cycle.
  - Confirm and key_ack on the same edge: key_code=cand, key_valid stays 1, no overrun.
- Handshake: key_ack=1 while key_valid=1 clears key_valid on that edge. key_ack while key_valid=0 is ignored. key_code holds its value after ack.
- Exactly one key_valid event per debounced press. Auto-repeat is not provided.
- Widths: slot counter $clog2(SLOT_CYCLES) bits; frame count $clog2(DEBOUNCE_FRAMES+1) bits, saturating; code arithmetic 4-bit, no overflow possible.

Decomposition:
- Package keypad_pkg: NUM_ROWS=4, NUM_COLS=4, CODE_W=4, frame-result enum {FR_NONE, FR_SINGLE, FR_MULTI}, debounce state enum {DB_IDLE, DB_CAND, DB_PRESSED, DB_REL}.
- One natural sub-module: keypad_debounce.
  - Inputs: frame_done, frame result, frame code.
  - Outputs: confirm pulse, code, key_held.
  - Owns the debounce FSM.
- Slot/column sequencing, frame accumulation and the valid/ack register stay in keypad_scan_ctrl.

Test Plan (SLOT_CYCLES=8, DEBOUNCE_FRAMES=3; bench models the keypad: key_in[r]=0 iff key (r,c) is closed and key_out[c]=0):
- Reset/idle: rst high 3 cycles, no keys -> key_out=4'b1110 after reset. key_out cycles 1110,1101,1011,0111 every 8 cycles. key_valid, key_held and key_overrun stay 0 for 10 frames.
- Single press: key (row 2, col 1) closed from frame start -> key_valid=1, key_code=9, key_held=1 one cycle after the 3rd frame close. key_ack pulse -> key_valid=0 next cycle. Key held 10 more frames -> no further key_valid.
- Bounce: (1,3) closed 2 frames, open 1 frame, closed 3 frames -> exactly one event, key_code=7, after frame 6.
- Release/repress: after the press, open 3 frames -> key_held falls after the 3rd open frame. Re-close (0,0) for 3 frames -> second event with key_code=0.
- Overrun and collision:
  - Confirm 5 without ack, release, then confirm 10 -> key_code stays 5, key_overrun high exactly 1 cycle.
  - Repeat with key_ack asserted on the confirm edge of 10 -> key_code=10, key_valid stays 1, no overrun.
- Multi-key/reset:
  - (0,0) and (3,3) closed together from IDLE -> no event.
  - (2,2) closed 2 frames, then rst pulse, then held 2 more frames -> no event. Held a 3rd frame after rst -> event with key_code=10.
